// File: rtl/vga_compositor_if.sv
// vga_compositor_if: CPU register port of the VGA compositor.
// master = bus decoder side, slave = compositor side.
interface vga_compositor_if;
   logic [3:0]  we_reg;
   logic [1:0]  reg_sel;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;

   modport master (output we_reg, output reg_sel, output reg_wdata, input reg_rdata);
   modport slave  (input we_reg, input reg_sel, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/vga_compositor.sv
// vga_compositor: VGA timing generator with pixel-clock divider and a
// LAYERS-deep priority compositor (enable, validity, colour key, background).
// Control registers are CPU-writable with byte enables and are shadowed so that
// the active copy only changes at frame start.
// Optional feature macro: VGA_COMP_BLINK_EN -- when defined, ctrl[23:16] hides
// the selected layers while frame_cnt[5] is set (64-frame period, 50% duty).
module vga_compositor #(
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned LAYERS   = 3,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIX_DIV  = 4,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned CNT_W    = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   vga_compositor_if.slave               bus,
   input  logic [LAYERS*3*COLOR_W-1:0]   layer_color,
   input  logic [LAYERS-1:0]             layer_valid,
   output logic [CNT_W-1:0]              column,
   output logic [CNT_W-1:0]              row,
   output logic                          pix_en,
   output logic                          frame_start,
   output logic [COLOR_W-1:0]            r,
   output logic [COLOR_W-1:0]            g,
   output logic [COLOR_W-1:0]            b,
   output logic                          hsync,
   output logic                          vsync,
   output logic                          busy
);

   localparam int unsigned PIX_W   = 3 * COLOR_W;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SS    = H_ACTIVE + H_FP;
   localparam int unsigned H_SE    = H_SS + H_SYNC;
   localparam int unsigned V_SS    = V_ACTIVE + V_FP;
   localparam int unsigned V_SE    = V_SS + V_SYNC;
   localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   // Layer-enable bits beyond LAYERS and colour bits beyond PIX_W never store.
   localparam logic [31:0] LAYER_MASK = 32'((64'd1 << LAYERS) - 64'd1);
   localparam logic [31:0] CTRL_MASK  = ~(32'h0000_00FF & ~LAYER_MASK);
   localparam logic [31:0] PIX_MASK   = 32'((64'd1 << PIX_W) - 64'd1);

   logic [DIV_W-1:0]  div;
   logic [CNT_W-1:0]  h_cnt;
   logic [CNT_W-1:0]  v_cnt;
   logic [7:0]        frame_cnt;

   logic [31:0]       ctrl_pend, key_pend, bg_pend;
   logic [31:0]       ctrl_nxt, key_nxt, bg_nxt;
   logic [LAYERS-1:0] lay_en_act;
   logic              key_en_act;
   logic              blank_act;
   logic [PIX_W-1:0]  key_act;
   logic [PIX_W-1:0]  bg_act;
   logic [LAYERS-1:0] blink_hide;

   logic              de;
   logic              vblank;
   logic              h_sync_win;
   logic              v_sync_win;
   logic [LAYERS-1:0] vis;
   logic [PIX_W-1:0]  mix;

   logic [PIX_W-1:0]  s1_rgb;
   logic              s1_hs;
   logic              s1_vs;

   assign pix_en      = (div == DIV_W'(PIX_DIV - 1));
   assign frame_start = pix_en && (h_cnt == CNT_W'(H_TOTAL - 1)) && (v_cnt == CNT_W'(V_TOTAL - 1));
   assign de          = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
   assign vblank      = (v_cnt >= CNT_W'(V_ACTIVE));
   assign h_sync_win  = (h_cnt >= CNT_W'(H_SS)) && (h_cnt < CNT_W'(H_SE));
   assign v_sync_win  = (v_cnt >= CNT_W'(V_SS)) && (v_cnt < CNT_W'(V_SE));
   assign busy        = de;
   assign column      = h_cnt;
   assign row         = v_cnt;

   // Byte-enable merge of write data into a register, then drop unimplemented bits.
   function automatic logic [31:0] apply_wr(input logic [31:0] cur, input logic [31:0] wd,
                                            input logic [3:0] be, input logic [31:0] mask);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[i*8 +: 8] = wd[i*8 +: 8];
      end
      return res & mask;
   endfunction

   // Pixel divider and h/v/frame counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         div       <= '0;
         h_cnt     <= '0;
         v_cnt     <= '0;
         frame_cnt <= '0;
      end else begin
         div <= pix_en ? '0 : div + DIV_W'(1);
         if (pix_en) begin
            if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
               h_cnt <= '0;
               if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
                  v_cnt     <= '0;
                  frame_cnt <= frame_cnt + 8'd1;
               end else begin
                  v_cnt <= v_cnt + CNT_W'(1);
               end
            end else begin
               h_cnt <= h_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Next pending values; also the write-bypass source for the frame-start reload.
   always_comb begin
      ctrl_nxt = ctrl_pend;
      key_nxt  = key_pend;
      bg_nxt   = bg_pend;
      case (bus.reg_sel)
         2'd0:    ctrl_nxt = apply_wr(ctrl_pend, bus.reg_wdata, bus.we_reg, CTRL_MASK);
         2'd1:    key_nxt  = apply_wr(key_pend, bus.reg_wdata, bus.we_reg, PIX_MASK);
         2'd2:    bg_nxt   = apply_wr(bg_pend, bus.reg_wdata, bus.we_reg, PIX_MASK);
         default: ;
      endcase
   end

   // Pending registers track CPU writes; active copies reload at frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_pend  <= '0;
         key_pend   <= '0;
         bg_pend    <= '0;
         lay_en_act <= '0;
         key_en_act <= 1'b0;
         blank_act  <= 1'b0;
         key_act    <= '0;
         bg_act     <= '0;
      end else begin
         ctrl_pend <= ctrl_nxt;
         key_pend  <= key_nxt;
         bg_pend   <= bg_nxt;
         if (frame_start) begin
            lay_en_act <= ctrl_nxt[LAYERS-1:0];
            key_en_act <= ctrl_nxt[8];
            blank_act  <= ctrl_nxt[9];
            key_act    <= key_nxt[PIX_W-1:0];
            bg_act     <= bg_nxt[PIX_W-1:0];
         end
      end
   end

`ifdef VGA_COMP_BLINK_EN
   logic [LAYERS-1:0] blink_act;

   // Active blink mask, reloaded with the other active fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_act <= '0;
      end else if (frame_start) begin
         blink_act <= ctrl_nxt[16 +: LAYERS];
      end
   end

   assign blink_hide = frame_cnt[5] ? blink_act : '0;
`else
   assign blink_hide = '0;
`endif

   // Priority mix: the highest-index visible layer overrides the background.
   always_comb begin
      mix = bg_act;
      vis = '0;
      for (int i = 0; i < LAYERS; i++) begin
         vis[i] = lay_en_act[i] && layer_valid[i] && !blink_hide[i] &&
                  !(key_en_act && (layer_color[i*PIX_W +: PIX_W] == key_act));
         if (vis[i]) mix = layer_color[i*PIX_W +: PIX_W];
      end
   end

   // Register read mux; status reflects live counters.
   always_comb begin
      case (bus.reg_sel)
         2'd0:    bus.reg_rdata = ctrl_pend;
         2'd1:    bus.reg_rdata = key_pend;
         2'd2:    bus.reg_rdata = bg_pend;
         default: bus.reg_rdata = {frame_cnt, vblank, 1'b0, 11'(v_cnt), 11'(h_cnt)};
      endcase
   end

   // Two pixel stages: S1 samples sources and mixes, S2 drives the pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_rgb  <= '0;
         s1_hs   <= ~SYNC_POL;
         s1_vs   <= ~SYNC_POL;
         r       <= '0;
         g       <= '0;
         b       <= '0;
         hsync   <= ~SYNC_POL;
         vsync   <= ~SYNC_POL;
      end else if (pix_en) begin
         s1_rgb    <= (de && !blank_act) ? mix : '0;
         s1_hs     <= h_sync_win ? SYNC_POL : ~SYNC_POL;
         s1_vs     <= v_sync_win ? SYNC_POL : ~SYNC_POL;
         {r, g, b} <= s1_rgb;
         hsync     <= s1_hs;
         vsync     <= s1_vs;
      end
   end

endmodule

// File: tb/tb_vga_compositor.sv
// tb_vga_compositor: small-geometry bench (H 8/2/2/2, V 4/1/1/1, PIX_DIV=2,
// LAYERS=3, COLOR_W=4). A cycle-count based reference model predicts every
// output each clock; literal expectations pin the key scenarios.
module tb_vga_compositor;
   localparam int HA = 8;
   localparam int HT = 14;
   localparam int VA = 4;
   localparam int VT = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [35:0] lc;
   logic [2:0]  lv;
   logic [9:0]  column, row;
   logic        pix_en, frame_start, hsync, vsync, busy;
   logic [3:0]  r, g, b;

   always #5 clk = ~clk;

   vga_compositor_if bus ();

   vga_compositor #(
      .COLOR_W(4), .LAYERS(3),
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .PIX_DIV(2), .SYNC_POL(1'b0), .CNT_W(10)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .layer_color(lc), .layer_valid(lv),
      .column(column), .row(row), .pix_en(pix_en), .frame_start(frame_start),
      .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .busy(busy)
   );

   int          checks = 0;
   int          failures = 0;
   int          n;
   logic [31:0] m_ctrl, m_key, m_bg;
   logic [31:0] a_ctrl, a_key, a_bg;
   logic [13:0] ring [0:7];
   logic [31:0] last_rdata;
   bit          lit_arm;
   logic [11:0] lit_val;
   string       lit_name;
   bit          rand_layers;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, n);
      end
   endtask

   function automatic logic [11:0] pick();
      case ($urandom_range(0, 4))
         0:       return 12'h111;
         1:       return 12'h222;
         2:       return 12'h333;
         3:       return 12'hABC;
         default: return 12'($urandom);
      endcase
   endfunction

   // Byte-lane write rule followed by masking of unimplemented bits.
   function automatic logic [31:0] wr_model(input logic [31:0] cur, input logic [31:0] wd,
                                            input logic [3:0] be, input logic [31:0] mask);
      logic [31:0] bm;
      bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return ((cur & ~bm) | (wd & bm)) & mask;
   endfunction

   // Scan layers from highest priority down; first visible one wins.
   function automatic logic [11:0] mix_model(input logic [31:0] c, input logic [31:0] k,
                                             input logic [31:0] bgv, input logic [35:0] col,
                                             input logic [2:0] val, input int fc);
      bit blink_on;
      blink_on = 1'b0;
`ifdef VGA_COMP_BLINK_EN
      blink_on = fc[5];
`endif
      for (int i = 2; i >= 0; i--) begin
         logic [11:0] ci;
         bit hidden;
         ci = col[i*12 +: 12];
         hidden = (c[8] && ci == k[11:0]) || (blink_on && c[16+i]);
         if (c[i] && val[i] && !hidden) return ci;
      end
      return bgv[11:0];
   endfunction

   function automatic bit is_fs(input int cyc_n);
      int k;
      k = cyc_n / 2;
      return (cyc_n % 2 == 1) && (k % HT == HT - 1) && ((k / HT) % VT == VT - 1);
   endfunction

   // One clock: compare outputs, drive inputs, advance the model.
   task automatic cyc(input logic [3:0] we, input logic [1:0] sel, input logic [31:0] wd);
      int k, h, v, fc, jo;
      logic [13:0] e;
      logic [31:0] exp_rd;
      k  = n / 2;
      h  = k % HT;
      v  = (k / HT) % VT;
      fc = (k / (HT * VT)) % 256;
      chk("column", 32'(column), 32'(h));
      chk("row", 32'(row), 32'(v));
      chk("pix_en", 32'(pix_en), 32'(n % 2));
      chk("frame_start", 32'(frame_start), 32'(is_fs(n)));
      chk("busy", 32'(busy), 32'(h < HA && v < VA));
      jo = k - 2;
      if (jo < 0) e = {1'b1, 1'b1, 12'h000};
      else        e = ring[jo % 8];
      chk("rgb", 32'({r, g, b}), 32'(e[11:0]));
      chk("hsync", 32'(hsync), 32'(e[13]));
      chk("vsync", 32'(vsync), 32'(e[12]));
      if (lit_arm && jo >= 0 && (jo % HT) < HA && ((jo / HT) % VT) < VA) begin
         chk(lit_name, 32'({r, g, b}), 32'(lit_val));
         lit_arm = 1'b0;
      end
      if (rand_layers) begin
         lc = {pick(), pick(), pick()};
         lv = 3'($urandom);
      end
      bus.we_reg    = we;
      bus.reg_sel   = sel;
      bus.reg_wdata = wd;
      #1;
      last_rdata = bus.reg_rdata;
      case (sel)
         2'd0:    exp_rd = m_ctrl;
         2'd1:    exp_rd = m_key;
         2'd2:    exp_rd = m_bg;
         default: exp_rd = {8'(fc), v >= VA, 1'b0, 11'(v), 11'(h)};
      endcase
      chk("reg_rdata", last_rdata, exp_rd);
      if (n % 2 == 1) begin
         e[13]   = !(h >= 10 && h < 12);
         e[12]   = !(v == 5);
         e[11:0] = (h < HA && v < VA && !a_ctrl[9]) ? mix_model(a_ctrl, a_key, a_bg, lc, lv, fc) : 12'h000;
         ring[k % 8] = e;
      end
      case (sel)
         2'd0:    m_ctrl = wr_model(m_ctrl, wd, we, 32'hFFFF_FF07);
         2'd1:    m_key  = wr_model(m_key, wd, we, 32'h0000_0FFF);
         2'd2:    m_bg   = wr_model(m_bg, wd, we, 32'h0000_0FFF);
         default: ;
      endcase
      if (is_fs(n)) begin
         a_ctrl = m_ctrl;
         a_key  = m_key;
         a_bg   = m_bg;
      end
      n++;
      @(negedge clk);
   endtask

   task automatic run(input int c);
      for (int i = 0; i < c; i++) cyc(4'b0000, 2'($urandom), $urandom);
   endtask

   task automatic run_until_fs();
      while (!is_fs(n)) run(1);
   endtask

   task automatic expect_lit(input string name, input logic [11:0] val);
      run(6);
      lit_name = name;
      lit_val  = val;
      lit_arm  = 1'b1;
      for (int i = 0; i < 200 && lit_arm; i++) run(1);
      if (lit_arm) begin
         checks++;
         failures++;
         $display("FAIL %s: no active pixel seen within 200 clk, expected %h", name, val);
         lit_arm = 1'b0;
      end
   endtask

   task automatic do_reset(input bit lits);
      rst = 1'b1;
      bus.we_reg = 4'b0000;
      @(negedge clk);
      if (lits) begin
         chk("rst_column", 32'(column), 32'd0);
         chk("rst_row", 32'(row), 32'd0);
         chk("rst_rgb", 32'({r, g, b}), 32'd0);
         chk("rst_hsync", 32'(hsync), 32'd1);
         chk("rst_vsync", 32'(vsync), 32'd1);
         bus.reg_sel = 2'd3;
         #1;
         chk("rst_frame_cnt", 32'(bus.reg_rdata[31:24]), 32'd0);
      end
      rst     = 1'b0;
      n       = 0;
      m_ctrl  = '0; m_key = '0; m_bg = '0;
      a_ctrl  = '0; a_key = '0; a_bg = '0;
      lit_arm = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int hs_low, vs_low, nz, guard;
      bit cond;
      logic [3:0]  rwe;
      logic [1:0]  rsel;
      logic [31:0] rwd;
      bus.we_reg = '0; bus.reg_sel = '0; bus.reg_wdata = '0;
      lc = '0; lv = '0; rand_layers = 1'b1;
      @(negedge clk);
      do_reset(1'b0);

      // Timing from reset release.
      run(23);
      chk("hs_before_first", 32'(hsync), 32'd1);
      run(1);
      chk("hs_first_low_clk24", 32'(hsync), 32'd0);
      run(3);
      chk("hs_low_clk27", 32'(hsync), 32'd0);
      run(1);
      chk("hs_high_clk28", 32'(hsync), 32'd1);
      run(195 - n);
      chk("fs_first_clk195", 32'(frame_start), 32'd1);

      // Fixed sources: L0=111, L1=222, L2=333.
      rand_layers = 1'b0;
      lc = {12'h333, 12'h222, 12'h111};
      lv = 3'b011;
      cyc(4'b0011, 2'd2, 32'h0000_0ABC);
      cyc(4'b0011, 2'd1, 32'h0000_0222);
      run_until_fs();
      cyc(4'b0000, 2'd0, 32'h0);
      expect_lit("bg_only", 12'hABC);

      // Mid-frame ctrl write is readable next clk but shown only next frame.
      run(40);
      cyc(4'b0001, 2'd0, 32'h0000_0007);
      cyc(4'b0000, 2'd0, 32'h0);
      chk("rd_ctrl_next_clk", last_rdata, 32'h0000_0007);
      lv = 3'b111;
      expect_lit("shadow_hold", 12'hABC);
      run_until_fs();
      cyc(4'b0000, 2'd0, 32'h0);
      expect_lit("layer2_after_fs", 12'h333);
      lv = 3'b011;
      expect_lit("priority_l1", 12'h222);
      lv = 3'b000;
      expect_lit("priority_bg", 12'hABC);

      // Colour key enabled by a write coincident with frame_start.
      lv = 3'b011;
      run_until_fs();
      cyc(4'b0010, 2'd0, 32'h0000_0100);
      expect_lit("key_on_bypass", 12'h111);
      run_until_fs();
      cyc(4'b0010, 2'd0, 32'h0000_0000);
      expect_lit("key_off", 12'h222);

      // Force blank for a whole frame; syncs keep running.
      lv = 3'b111;
      run_until_fs();
      cyc(4'b0010, 2'd0, 32'h0000_0200);
      hs_low = 0; vs_low = 0; nz = 0;
      for (int i = 0; i < 196; i++) begin
         if (hsync == 1'b0) hs_low++;
         if (vsync == 1'b0) vs_low++;
         if ({r, g, b} != 12'h000) nz++;
         run(1);
      end
      chk("blank_hs_low_per_frame", 32'(hs_low), 32'd28);
      chk("blank_vs_low_per_frame", 32'(vs_low), 32'd28);
      chk("blank_nonzero_rgb", 32'(nz), 32'd0);
      cyc(4'b0010, 2'd0, 32'h0000_0000);

      // Randomized traffic.
      rand_layers = 1'b1;
      for (int i = 0; i < 2400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            rsel = 2'($urandom);
            rwe  = 4'($urandom);
            rwd  = $urandom;
            if (rsel != 2'd0) rwd[11:0] = pick();
            else if ($urandom_range(0, 3) != 0) rwd[9] = 1'b0;
            cyc(rwe, rsel, rwd);
         end else begin
            run(1);
         end
      end

      // Reset in the middle of line 2, column 5.
      guard = 0;
      cond = 1'b0;
      while (!cond && guard < 300) begin
         cond = ((n / 2) % HT == 5) && (((n / 2) / HT) % VT == 2);
         if (!cond) run(1);
         guard++;
      end
      chk("reached_h5_v2", 32'(cond), 32'd1);
      do_reset(1'b1);
      run(195);
      chk("fs_one_frame_after_reset", 32'(frame_start), 32'd1);
      run(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_compositor.md
Name: vga_compositor

Overview:
- Parametrised successor display engine for the SoC VGA path. Integrates its own resolution-parametrised timing generator and a pixel-clock divider running off the single system clock.
- Composites LAYERS colour sources with per-layer enable, validity and colour-key transparency over a background colour.
- Control registers are CPU-writable with byte enables and shadowed, so updates take effect only at frame start.
- Sits between the CPU bus decoder and the text/graph/cursor layer generators; drives the board VGA pins.

Parameters:
- COLOR_W, 4, bits per colour channel; pixel word is 3*COLOR_W = {r,g,b}.
- LAYERS, 3, number of composited sources (1..8); higher index has higher priority.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- PIX_DIV, 4, clk cycles per pixel (>=1).
- SYNC_POL, 0, asserted level of hsync/vsync.
- CNT_W, 10, width of column/row outputs.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- we_reg, in, 4, byte write enables for the selected register.
- reg_sel, in, 2, register select: 0 ctrl, 1 colour key, 2 background, 3 status (read-only).
- reg_wdata, in, 32, write data.
- reg_rdata, out, 32, combinational read of the selected register.
- layer_color, in, LAYERS*3*COLOR_W, layer i occupies [i*3*COLOR_W +: 3*COLOR_W].
- layer_valid, in, LAYERS, per-pixel opacity from each layer.
- column, out, CNT_W, current h_cnt.
- row, out, CNT_W, current v_cnt.
- pix_en, out, 1, pixel strobe.
- frame_start, out, 1, one-clk pulse on the pix_en that wraps the counters to (0,0).
- r, out, COLOR_W, red.
- g, out, COLOR_W, green.
- b, out, COLOR_W, blue.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- busy, out, 1, high while (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).

Behaviour:
- Divider:
  - div counts 0..PIX_DIV-1; pix_en=(div==PIX_DIV-1).
  - PIX_DIV=1 gives pix_en constantly high.
- Counters (advance on pix_en only):
  - h_cnt wraps at H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 to 0 and increments 8-bit frame_cnt (mod 256).
- Pipeline, 2 pixel stages:
  - S1 samples layer_color/layer_valid one pix_en after column/row are presented, i.e. sources have a 1-pixel fetch latency.
  - S2 registers r/g/b/hsync/vsync.
  - Sync and de flags are delayed through both stages, so rgb and syncs are aligned.
- Sync timing: hsync asserted (=SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt.
- Mixing at S1:
  - Layer i is visible if ctrl_act[i] && layer_valid[i] && !(ctrl_act[8] && color_i==key_act).
  - The highest visible index wins; if none is visible, bg_act.
  - rgb=0 when !de or ctrl_act[9] (force blank).
- Registers, pending copy:
  - ctrl[31:0]: [7:0] layer enable, [8] key enable, [9] force blank, [23:16] blink mask. Bits at or above LAYERS in [7:0] read 0.
  - key and bg hold 3*COLOR_W bits, LSB-aligned; upper bits read 0.
  - Byte-enable writes take effect on the next clk.
  - reg_sel=3 ignores writes and reads {frame_cnt[7:0], vblank, 1'b0, v_cnt[CNT_W-1:0] zero-extended to 11, h_cnt zero-extended to 11}.
  - Reads of sel 0..2 return the pending values.
- Shadowing:
  - active <= pending on the frame_start clk.
  - A write in that same clk is included (write bypass): active takes the newly written bytes.
- Reset:
  - r/g/b=0, hsync=vsync=~SYNC_POL, pix_en=0, frame_start=0.
  - Counters, div, frame_cnt, pipeline, pending and active registers all cleared; busy=1 (counters at 0,0).
  - Reset mid-frame restarts the frame from (0,0) on the next clk; the next frame_start occurs one full frame later.

Optional Feature:
- Macro: VGA_COMP_BLINK_EN.
- Defined: when frame_cnt[5]==1, a layer i with ctrl_act[16+i] set is treated as invisible. Period is 64 frames, 50% duty.
- Undefined: ctrl[23:16] is stored and readable but has no effect on mixing.

Test Plan:
Bench parameters for all scenarios: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), PIX_DIV=2, LAYERS=3, COLOR_W=4.
- Timing: release reset -> hsync low for 4 clk every 28 clk; first low at clk 2*(10+2); vsync low 28 clk per 196-clk frame; frame_start period 196.
- Priority: all layers enabled, valid=3'b011, L0=0x111, L1=0x222 -> rgb=0x222; valid=3'b000 with bg=0xABC -> rgb=0xABC.
- Colour key: key=0x222 with ctrl[8]=1, valid=3'b011 -> rgb=0x111; ctrl[8]=0 -> 0x222.
- Shadow: mid-frame write ctrl=0x7 -> reg_rdata=0x7 next clk; layer 2 pixels are not shown until after the next frame_start; a write coincident with frame_start is applied in that frame.
- Blanking: during h_cnt 8..13, rgb=0 with all layers valid; ctrl[9]=1 -> rgb=0 for an entire frame while syncs keep toggling.
- Reset mid-line (h_cnt=5, v_cnt=2) -> next clk: column=row=0, rgb=0, hsync=vsync=1, status frame_cnt=0.
